pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage core. It drives the hold and bubble controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves four hazard sources in a fixed priority order: cache misses, multi-cycle EX operations, branch mispredicts and load-use. It owns the multi-cycle EX busy counter and optional hazard performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_hazard_perf_cnt.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
// The optional performance counters are enabled with HAZARD_PERF_CNT_EN.
package pipe_hazard_ctrl_pkg;

  localparam int REGS_WID   = 5;
  localparam int MC_CNT_WID = 4;

  typedef enum logic {
    RUN,
    MC_BUSY
  } hc_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the stall/flush controls returned to it.
// The slave side is the hazard controller; HAZARD_PERF_CNT_EN does not change this bundle.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic                icache_stall;
  logic                dcache_stall;
  logic [REGS_WID-1:0] id_rs1;
  logic [REGS_WID-1:0] id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [REGS_WID-1:0] ex_rd;
  logic                ex_mem_read;
  logic                ex_mc_start;
  logic                ex_mispredict;

  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic ex_mem_stall;
  logic mem_wb_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mc_busy;

  modport master (
    output icache_stall, dcache_stall, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_mem_read, ex_mc_start, ex_mispredict,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mc_busy
  );

  modport slave (
    input  icache_stall, dcache_stall, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_mem_read, ex_mc_start, ex_mispredict,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mc_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_perf_cnt.sv
// Bank of four saturating hazard counters, instantiated only when HAZARD_PERF_CNT_EN is defined.
// inc[0]=cache cycles, inc[1]=load-use bubbles, inc[2]=multi-cycle cycles, inc[3]=mispredict flushes.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       inc,
  output logic [CNT_W-1:0] perf_cache_cyc,
  output logic [CNT_W-1:0] perf_lu_cyc,
  output logic [CNT_W-1:0] perf_mc_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign perf_cache_cyc = cnt_q[0];
  assign perf_lu_cyc    = cnt_q[1];
  assign perf_mc_cyc    = cnt_q[2];
  assign perf_flush_cnt = cnt_q[3];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core; owns the multi-cycle EX busy counter.
// Define HAZARD_PERF_CNT_EN to add the saturating hazard performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_cache_cyc,
  output logic [CNT_W-1:0]  perf_lu_cyc,
  output logic [CNT_W-1:0]  perf_mc_cyc,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  if ((MC_LAT < 2) || (MC_LAT > 15) || (CNT_W < 1)) begin : g_bad_param
    $error("pipe_hazard_ctrl: MC_LAT must be 2..15 and CNT_W at least 1");
  end

  hc_state_e               state_q, state_d;
  logic [MC_CNT_WID-1:0]   mc_cnt_q, mc_cnt_d;

  logic cache;
  logic load_use;
  logic mc_start_run;
  logic mc_active;

  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mc_busy;

  assign cache        = hz.icache_stall | hz.dcache_stall;
  assign load_use     = hz.ex_mem_read && (hz.ex_rd != '0) &&
                        ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                         (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
  // The op's first cycle in EX already behaves as busy, before the state flop catches up.
  assign mc_start_run = (state_q == RUN) && hz.ex_mc_start;
  assign mc_active    = (state_q == MC_BUSY) || mc_start_run;

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mc_busy      = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      mc_busy = (state_q == MC_BUSY) || (mc_start_run && !cache);
      if (cache) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end else if (mc_active) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (hz.ex_mispredict) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  // A cache miss freezes the whole pipe, including the busy countdown.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    if (!cache) begin
      case (state_q)
        RUN: begin
          if (hz.ex_mc_start) begin
            state_d  = MC_BUSY;
            mc_cnt_d = MC_CNT_WID'(MC_LAT - 1);
          end
        end
        MC_BUSY: begin
          if (mc_cnt_q == MC_CNT_WID'(1)) begin
            state_d  = RUN;
            mc_cnt_d = '0;
          end else begin
            mc_cnt_d = mc_cnt_q - MC_CNT_WID'(1);
          end
        end
        default: begin
          state_d  = RUN;
          mc_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.id_ex_stall  = id_ex_stall;
  assign hz.ex_mem_stall = ex_mem_stall;
  assign hz.mem_wb_stall = mem_wb_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.mc_busy      = mc_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] perf_inc;

  // Only the hazard that wins the priority order is counted.
  assign perf_inc[0] = !rst && cache;
  assign perf_inc[1] = !rst && !cache && !mc_active && !hz.ex_mispredict && load_use;
  assign perf_inc[2] = !rst && !cache && mc_active;
  assign perf_inc[3] = !rst && !cache && !mc_active && hz.ex_mispredict;

  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk            (clk),
    .rst            (rst),
    .inc            (perf_inc),
    .perf_cache_cyc (perf_cache_cyc),
    .perf_lu_cyc    (perf_lu_cyc),
    .perf_mc_cyc    (perf_mc_cyc),
    .perf_flush_cnt (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (MC_LAT=4).
// With HAZARD_PERF_CNT_EN defined it also exercises the 2-bit saturating counters.
module tb_pipe_hazard_ctrl;

  localparam int TB_MC_LAT = 4;
  localparam int TB_CNT_W  = 2;

  // Expected output word: {pc, if_id, id_ex, ex_mem, mem_wb stalls, if_id, id_ex, ex_mem flushes, mc_busy}
  localparam logic [8:0] E_IDLE     = 9'b00000_000_0;
  localparam logic [8:0] E_RST      = 9'b00000_111_0;
  localparam logic [8:0] E_LU       = 9'b11000_010_0;
  localparam logic [8:0] E_MISP     = 9'b00000_110_0;
  localparam logic [8:0] E_MC       = 9'b11100_001_1;
  localparam logic [8:0] E_CACHE    = 9'b11111_000_0;
  localparam logic [8:0] E_CACHE_MC = 9'b11111_000_1;

  typedef struct {
    logic       icache;
    logic       dcache;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       mem_read;
    logic       mc_start;
    logic       misp;
    logic [8:0] exp;
    string      name;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if hz_if ();

`ifdef HAZARD_PERF_CNT_EN
  logic [TB_CNT_W-1:0] perf_cache_cyc;
  logic [TB_CNT_W-1:0] perf_lu_cyc;
  logic [TB_CNT_W-1:0] perf_mc_cyc;
  logic [TB_CNT_W-1:0] perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(
    .MC_LAT (TB_MC_LAT),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hz             (hz_if)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_cache_cyc (perf_cache_cyc),
    .perf_lu_cyc    (perf_lu_cyc),
    .perf_mc_cyc    (perf_mc_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of stimulus just after the rising edge.
  task automatic applyStimulus(input vec_t v, input logic r);
    @(posedge clk);
    #1;
    rst                 = r;
    hz_if.icache_stall  = v.icache;
    hz_if.dcache_stall  = v.dcache;
    hz_if.id_rs1        = v.rs1;
    hz_if.id_rs2        = v.rs2;
    hz_if.id_use_rs1    = v.use1;
    hz_if.id_use_rs2    = v.use2;
    hz_if.ex_rd         = v.rd;
    hz_if.ex_mem_read   = v.mem_read;
    hz_if.ex_mc_start   = v.mc_start;
    hz_if.ex_mispredict = v.misp;
  endtask

  // Samples the combinational controls on the falling edge of the same cycle.
  task automatic checkOutput(input string name, input logic [8:0] exp);
    logic [8:0] act;
    @(negedge clk);
    act = {hz_if.pc_stall, hz_if.if_id_stall, hz_if.id_ex_stall, hz_if.ex_mem_stall,
           hz_if.mem_wb_stall, hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.ex_mem_flush,
           hz_if.mc_busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic checkCounter(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic stepCheck(input vec_t v, input logic r, input string name, input logic [8:0] exp);
    applyStimulus(v, r);
    checkOutput(name, exp);
  endtask

  vec_t vecs [10];
  vec_t idle;
  vec_t v;

  initial begin
    checks = 0;
    errors = 0;

    idle = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE, "idle"};
    //         icache dcache rs1  rs2  use1 use2 rd  mrd mc misp exp name
    vecs[0] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE,  "tbl_idle"};
    vecs[1] = '{1'b0, 1'b0, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_LU,    "tbl_lu_rs2"};
    vecs[2] = '{1'b0, 1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, E_IDLE,  "tbl_lu_rd0"};
    vecs[3] = '{1'b0, 1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, E_LU,    "tbl_lu_rs1"};
    vecs[4] = '{1'b0, 1'b0, 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, E_IDLE,  "tbl_lu_unused_rs1"};
    vecs[5] = '{1'b0, 1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, E_IDLE,  "tbl_no_load"};
    vecs[6] = '{1'b0, 1'b0, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, E_MISP,  "tbl_misp_over_lu"};
    vecs[7] = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, E_CACHE, "tbl_icache_misp"};
    vecs[8] = '{1'b0, 1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_CACHE, "tbl_dcache_lu"};
    vecs[9] = '{1'b0, 1'b0, 5'd1, 5'd1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, E_MISP,  "tbl_misp"};

    rst                 = 1'b1;
    hz_if.icache_stall  = 1'b0;
    hz_if.dcache_stall  = 1'b0;
    hz_if.id_rs1        = '0;
    hz_if.id_rs2        = '0;
    hz_if.id_use_rs1    = 1'b0;
    hz_if.id_use_rs2    = 1'b0;
    hz_if.ex_rd         = '0;
    hz_if.ex_mem_read   = 1'b0;
    hz_if.ex_mc_start   = 1'b0;
    hz_if.ex_mispredict = 1'b0;

    $display("[TB] reset");
    stepCheck(idle, 1'b1, "rst_c0", E_RST);
    stepCheck(idle, 1'b1, "rst_c1", E_RST);
    stepCheck(idle, 1'b0, "rst_release", E_IDLE);

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      stepCheck(vecs[i], 1'b0, vecs[i].name, vecs[i].exp);
    end

    $display("[TB] cache stall then mispredict");
    v = idle; v.icache = 1'b1; v.misp = 1'b1;
    stepCheck(v, 1'b0, "cm_cache", E_CACHE);
    v.icache = 1'b0;
    stepCheck(v, 1'b0, "cm_misp", E_MISP);

    $display("[TB] multi-cycle op");
    v = idle; v.mc_start = 1'b1;
    stepCheck(v, 1'b0, "mc_t0", E_MC);
    stepCheck(v, 1'b0, "mc_t1", E_MC);
    v.misp = 1'b1;
    stepCheck(v, 1'b0, "mc_t2_misp", E_MC);
    stepCheck(v, 1'b0, "mc_t3_misp", E_MC);
    stepCheck(idle, 1'b0, "mc_t4_run", E_IDLE);

    $display("[TB] multi-cycle op with dcache stall");
    v = idle; v.mc_start = 1'b1;
    stepCheck(v, 1'b0, "mcd_t0", E_MC);
    v.dcache = 1'b1;
    stepCheck(v, 1'b0, "mcd_t1_stall", E_CACHE_MC);
    stepCheck(v, 1'b0, "mcd_t2_stall", E_CACHE_MC);
    v.dcache = 1'b0;
    stepCheck(v, 1'b0, "mcd_t3", E_MC);
    stepCheck(v, 1'b0, "mcd_t4", E_MC);
    stepCheck(v, 1'b0, "mcd_t5", E_MC);
    stepCheck(idle, 1'b0, "mcd_t6_run", E_IDLE);

    $display("[TB] multi-cycle start blocked by cache");
    v = idle; v.mc_start = 1'b1; v.icache = 1'b1;
    stepCheck(v, 1'b0, "mcb_cache", E_CACHE);
    v.icache = 1'b0;
    stepCheck(v, 1'b0, "mcb_t0", E_MC);
    stepCheck(v, 1'b0, "mcb_t1", E_MC);
    stepCheck(v, 1'b0, "mcb_t2", E_MC);
    stepCheck(v, 1'b0, "mcb_t3", E_MC);
    stepCheck(idle, 1'b0, "mcb_run", E_IDLE);

    $display("[TB] reset during multi-cycle op");
    v = idle; v.mc_start = 1'b1;
    stepCheck(v, 1'b0, "mcr_t0", E_MC);
    stepCheck(v, 1'b1, "mcr_rst", E_RST);
    stepCheck(idle, 1'b0, "mcr_aborted", E_IDLE);

`ifdef HAZARD_PERF_CNT_EN
    $display("[TB] performance counters");
    stepCheck(idle, 1'b1, "pc_rst", E_RST);
    v = idle; v.icache = 1'b1;
    for (int i = 0; i < 3; i++) stepCheck(v, 1'b0, "pc_cache", E_CACHE);
    stepCheck(vecs[1], 1'b0, "pc_lu", E_LU);
    v = idle; v.misp = 1'b1;
    for (int i = 0; i < 2; i++) stepCheck(v, 1'b0, "pc_misp", E_MISP);
    stepCheck(vecs[6], 1'b0, "pc_misp_lu", E_MISP);
    stepCheck(idle, 1'b0, "pc_idle", E_IDLE);
    checkCounter("perf_cache", int'(perf_cache_cyc), 3);
    checkCounter("perf_lu", int'(perf_lu_cyc), 1);
    checkCounter("perf_flush", int'(perf_flush_cnt), 3);
    checkCounter("perf_mc", int'(perf_mc_cyc), 0);
    v = idle; v.icache = 1'b1;
    for (int i = 0; i < 2; i++) stepCheck(v, 1'b0, "pc_cache_sat", E_CACHE);
    stepCheck(idle, 1'b0, "pc_idle2", E_IDLE);
    checkCounter("perf_cache_saturated", int'(perf_cache_cyc), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
